serial_word_deserializer: RTL and testbench



---
 rtl/serial_word_deserializer.sv | 175 +++++++++++++++++
 tb/tb_serial_word_deserializer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: collects an LSB-first serial bitstream into a BITS-wide word with valid/ready output.
// Optional feature macro DESER_PARITY_EN: a trailing even-parity bit per word, checked into parity_err.
module serial_word_deserializer #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ser_in,
  input  logic            ser_valid,
  output logic [BITS-1:0] data,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            overrun,
  output logic            parity_err
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
`ifdef DESER_PARITY_EN
  localparam int NSLOT = BITS;
`else
  // The last data bit is taken straight from ser_in into the word, so it needs no slot.
  localparam int NSLOT = BITS - 1;
`endif

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PARITY  = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

`ifdef DESER_PARITY_EN
  function automatic logic even_parity(input logic [BITS-1:0] w);
    even_parity = ^w;
  endfunction
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] data_q, data_d;
  logic            data_valid_q, data_valid_d;
  logic            overrun_q, overrun_d;
  logic            cap_s;
  logic [NSLOT-1:0] slot_s;
`ifdef DESER_PARITY_EN
  logic            parity_err_q, parity_err_d;
`else
  logic [BITS-1:0] word_s;
  assign word_s = {ser_in, slot_s};
`endif

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    logic slot_bit_d, slot_bit_q;

    always_comb begin
      if (cap_s && (cnt_q == CW'(k))) begin
        slot_bit_d = ser_in;
      end else begin
        slot_bit_d = slot_bit_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_bit_q <= 1'b0;
      end else begin
        slot_bit_q <= slot_bit_d;
      end
    end

    assign slot_s[k] = slot_bit_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
`ifdef DESER_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    cap_s        = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (ser_valid) begin
          cap_s = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = {CW{1'b0}};
`ifdef DESER_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d      = ST_FULL;
            data_d       = word_s;
            data_valid_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef DESER_PARITY_EN
      ST_PARITY: begin
        if (ser_valid) begin
          state_d      = ST_FULL;
          data_d       = slot_s;
          data_valid_d = 1'b1;
          parity_err_d = even_parity(slot_s) ^ ser_in;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_FULL: begin
        if (data_ready) begin
          state_d      = ST_COLLECT;
          data_valid_d = 1'b0;
`ifdef DESER_PARITY_EN
          parity_err_d = 1'b0;
`endif
          // A bit arriving with the handshake becomes slot 0 of the next word.
          if (ser_valid) begin
            cap_s = 1'b1;
            cnt_d = CW'(1);
          end else begin
            cnt_d = {CW{1'b0}};
          end
        end else if (ser_valid) begin
          overrun_d = 1'b1;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d      = ST_COLLECT;
        cnt_d        = {CW{1'b0}};
        data_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COLLECT;
      cnt_q        <= {CW{1'b0}};
      data_q       <= {BITS{1'b0}};
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer: directed scenarios plus randomized traffic
// checked against a bit-queue reference model (honours DESER_PARITY_EN).
module tb_serial_word_deserializer;
  localparam int BITS = 4;
`ifdef DESER_PARITY_EN
  localparam int NB = BITS + 1;
`else
  localparam int NB = BITS;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ser_in = 1'b0;
  logic            ser_valid = 1'b0;
  logic            data_ready = 1'b0;
  logic [BITS-1:0] data;
  logic            data_valid;
  logic            overrun;
  logic            parity_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: accepted bits of the word in progress, plus the presented word.
  bit              mq[$];
  logic [BITS-1:0] m_word;
  bit              m_pending;
  bit              m_overrun;
  bit              m_perr;

  serial_word_deserializer #(.BITS(BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_word    = '0;
    m_pending = 1'b0;
    m_overrun = 1'b0;
    m_perr    = 1'b0;
  endtask

  task automatic model_clock(input bit sv, input bit si, input bit dr);
    if (m_pending) begin
      if (dr) begin
        m_pending = 1'b0;
        m_perr    = 1'b0;
        if (sv) mq.push_back(si);
      end else if (sv) begin
        m_overrun = 1'b1;
      end
    end else if (sv) begin
      mq.push_back(si);
      if (mq.size() == NB) begin
        for (int k = 0; k < BITS; k++) m_word[k] = mq[k];
`ifdef DESER_PARITY_EN
        m_perr = (^m_word) ^ mq[BITS];
`else
        m_perr = 1'b0;
`endif
        mq.delete();
        m_pending = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return at the following negedge.
  task automatic step(input bit sv, input bit si, input bit dr);
    ser_valid  = sv;
    ser_in     = si;
    data_ready = dr;
    @(posedge clk);
    model_clock(sv, si, dr);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    ser_valid  = 1'b0;
    ser_in     = 1'b0;
    data_ready = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sends one word LSB first, followed by its correct parity bit when parity is enabled.
  task automatic send_word(input logic [BITS-1:0] w, input bit dr);
    for (int i = 0; i < BITS; i++) step(1'b1, w[i], dr);
`ifdef DESER_PARITY_EN
    step(1'b1, ^w, dr);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (data !== 4'h0 || data_valid !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got data=%h dv=%b ov=%b pe=%b required all 0", data, data_valid, overrun, parity_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [BITS-1:0] w;
    w = 4'b1101;
    apply_reset();
    for (int i = 0; i < NB; i++) begin
      tests_run++;
      if (data_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_early_valid before bit %0d got %b required 0", i, data_valid);
      end
      if (i < BITS) step(1'b1, w[i], 1'b0);
      else          step(1'b1, ^w, 1'b0);
    end
    tests_run++;
    if (data !== 4'b1101 || data_valid !== 1'b1 || overrun !== 1'b0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_word got data=%b dv=%b ov=%b pe=%b required 1101 1 0 0", data, data_valid, overrun, parity_err);
    end
  endtask

  task automatic test_overrun();
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (overrun !== 1'b1 || data !== 4'b1101 || data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set got ov=%b data=%b dv=%b required 1 1101 1", overrun, data, data_valid);
    end
    step(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (overrun !== 1'b1 || data !== 4'b1101) begin
      tests_failed++;
      $display("FAIL overrun_hold got ov=%b data=%b required 1 1101", overrun, data);
    end
    step(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (data_valid !== 1'b0 || data !== 4'b1101 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_handshake got dv=%b data=%b ov=%b required 0 1101 1", data_valid, data, overrun);
    end
    step(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_sticky got %b required 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    bit              stream[$];
    logic [BITS-1:0] seen[$];
    logic [BITS-1:0] w;
    bit              prev_valid;
    apply_reset();
    w = 4'hA;
    for (int i = 0; i < BITS; i++) stream.push_back(w[i]);
`ifdef DESER_PARITY_EN
    stream.push_back(^w);
`endif
    w = 4'h5;
    for (int i = 0; i < BITS; i++) stream.push_back(w[i]);
`ifdef DESER_PARITY_EN
    stream.push_back(^w);
`endif
    prev_valid = 1'b0;
    for (int i = 0; i <= stream.size(); i++) begin
      if (i < stream.size()) step(1'b1, stream[i], 1'b1);
      else                   step(1'b0, 1'b0, 1'b1);
      tests_run++;
      if (data_valid !== m_pending || data !== m_word) begin
        tests_failed++;
        $display("FAIL b2b_step%0d got dv=%b data=%h required %b %h", i, data_valid, data, m_pending, m_word);
      end
      tests_run++;
      if (data_valid === 1'b1 && prev_valid) begin
        tests_failed++;
        $display("FAIL b2b_pulse_width step%0d got valid 2 cycles required 1", i);
      end
      if (data_valid === 1'b1) seen.push_back(data);
      prev_valid = (data_valid === 1'b1);
    end
    tests_run++;
    if (seen.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_word_count got %0d required 2", seen.size());
    end else begin
      tests_run++;
      if (seen[0] !== 4'hA || seen[1] !== 4'h5) begin
        tests_failed++;
        $display("FAIL b2b_words got %h,%h required a,5", seen[0], seen[1]);
      end
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_overrun got %b required 0", overrun);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_word(4'h5, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    ser_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (data !== 4'h0 || data_valid !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got data=%h dv=%b ov=%b pe=%b required all 0", data, data_valid, overrun, parity_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_word(4'h8, 1'b0);
    tests_run++;
    if (data !== 4'h8 || data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset_next_word got data=%h dv=%b required 8 1", data, data_valid);
    end
  endtask

  task automatic test_gaps();
    logic [8:0] vpat;
    logic [8:0] bpat;
    apply_reset();
    vpat = 9'b100101001;
    bpat = 9'b100000001;
    for (int i = 0; i < 9; i++) begin
      step(vpat[i], vpat[i] ? bpat[i] : 1'($urandom_range(0, 1)), 1'b0);
      tests_run++;
      if (data_valid !== m_pending) begin
        tests_failed++;
        $display("FAIL gaps_valid step%0d got %b required %b", i, data_valid, m_pending);
      end
    end
`ifdef DESER_PARITY_EN
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
`endif
    tests_run++;
    if (data !== 4'h9 || data_valid !== 1'b1 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL gaps_word got data=%h dv=%b pe=%b required 9 1 0", data, data_valid, parity_err);
    end
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    logic [BITS-1:0] w;
    apply_reset();
    w = 4'h3;
    for (int i = 0; i < BITS; i++) step(1'b1, w[i], 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (data !== 4'h3 || data_valid !== 1'b1 || parity_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_bad got data=%h dv=%b pe=%b required 3 1 1", data, data_valid, parity_err);
    end
    step(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (parity_err !== 1'b0 || data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_clear got pe=%b dv=%b required 0 0", parity_err, data_valid);
    end
    for (int i = 0; i < BITS; i++) step(1'b1, w[i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (data !== 4'h3 || data_valid !== 1'b1 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_good got data=%h dv=%b pe=%b required 3 1 0", data, data_valid, parity_err);
    end
  endtask
`endif

  task automatic test_random();
    int thr;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      thr = (c < 400) ? 100 : 40;
      step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < thr));
      tests_run++;
      if (data !== m_word || data_valid !== m_pending || overrun !== m_overrun || parity_err !== m_perr) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got data=%h dv=%b ov=%b pe=%b required %h %b %b %b",
                 c, data, data_valid, overrun, parity_err, m_word, m_pending, m_overrun, m_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_gaps();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
